// File: rtl/xcorr_peak_lag.sv
// Peak-lag finder for the mic cross-correlator: scans one frame of 2*MAX_LAG+1
// signed correlation results and publishes the lag, value and weakness of the maximum.
module xcorr_peak_lag #(
  parameter int RESULT_W = 32,
  parameter int MAX_LAG  = 31,
  parameter int LAG_W    = 6,
  parameter int MIN_PEAK = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       result_valid,
  input  logic signed [RESULT_W-1:0] result,
  output logic signed [LAG_W-1:0]    lag_diff,
  output logic signed [RESULT_W-1:0] peak_value,
  output logic                       lag_valid,
  output logic                       no_peak,
  output logic                       busy,
  output logic                       frame_err
);

  localparam int IDX_W = $clog2(2 * MAX_LAG + 1);
  localparam logic [IDX_W-1:0]           LAST_IDX   = IDX_W'(2 * MAX_LAG);
  localparam logic signed [RESULT_W-1:0] MOST_NEG   = {1'b1, {(RESULT_W-1){1'b0}}};
  localparam logic signed [RESULT_W-1:0] MIN_PEAK_S = RESULT_W'(MIN_PEAK);
  localparam logic signed [LAG_W:0]      MAX_LAG_S  = (LAG_W+1)'(MAX_LAG);

  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]           idx_p0, best_idx_p0;
  logic signed [RESULT_W-1:0] max_p0;

  logic [IDX_W-1:0]           base_idx, base_best, nxt_idx, nxt_best;
  logic signed [RESULT_W-1:0] base_max, nxt_max;
  logic                       accept, last, abort;

  // Index is a zero-based offset; widen before removing the centre so the result is exact.
  function automatic logic signed [LAG_W-1:0] to_lag(input logic [IDX_W-1:0] idx);
    logic signed [LAG_W:0] wide;
    wide = signed'((LAG_W+1)'(idx)) - MAX_LAG_S;
    return wide[LAG_W-1:0];
  endfunction

  function automatic logic is_weak(input logic signed [RESULT_W-1:0] peak);
    return peak <= MIN_PEAK_S;
  endfunction

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    base_idx  = idx_p0;
    base_max  = max_p0;
    base_best = best_idx_p0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          base_idx  = '0;
          base_max  = MOST_NEG;
          base_best = '0;
        end
      end
      ACCUM: begin
        // A restart strobe re-seeds the scan; a sample in the same cycle becomes index 0.
        if (start) begin
          abort     = 1'b1;
          base_idx  = '0;
          base_max  = MOST_NEG;
          base_best = '0;
        end
        if (result_valid) begin
          accept = 1'b1;
          if (base_idx == LAST_IDX) begin
            last      = 1'b1;
            state_nxt = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        if (start) begin
          state_nxt = ACCUM;
          base_idx  = '0;
          base_max  = MOST_NEG;
          base_best = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    nxt_idx  = base_idx;
    nxt_max  = base_max;
    nxt_best = base_best;
    // Strict compare keeps the earliest index on ties.
    if (accept) begin
      if (result > base_max) begin
        nxt_max  = result;
        nxt_best = base_idx;
      end
      nxt_idx = base_idx + IDX_W'(1);
    end
  end

  // Scan state and published outputs, all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx_p0      <= '0;
      best_idx_p0 <= '0;
      max_p0      <= MOST_NEG;
      lag_diff    <= '0;
      peak_value  <= '0;
      lag_valid   <= 1'b0;
      no_peak     <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx_p0      <= nxt_idx;
      best_idx_p0 <= nxt_best;
      max_p0      <= nxt_max;
      lag_valid   <= last;
      frame_err   <= abort;
      busy        <= (state_nxt == ACCUM);
      if (last) begin
        lag_diff   <= to_lag(nxt_best);
        peak_value <= nxt_max;
        no_peak    <= is_weak(nxt_max);
      end
    end
  end

endmodule

// File: tb/tb_xcorr_peak_lag.sv
// Randomized self-checking bench for xcorr_peak_lag against an array-based peak model.
module tb_xcorr_peak_lag;

  localparam int RESULT_W = 32;
  localparam int MAX_LAG  = 31;
  localparam int LAG_W    = 6;
  localparam int MIN_PEAK = 0;
  localparam int N        = 2 * MAX_LAG + 1;
  localparam int S_NONE = 0, S_SEP = 1, S_WITH = 2;

  logic clk = 1'b0;
  logic rst, start, result_valid;
  logic signed [RESULT_W-1:0] result;
  logic signed [LAG_W-1:0]    lag_diff;
  logic signed [RESULT_W-1:0] peak_value;
  logic lag_valid, no_peak, busy, frame_err;

  int errors = 0;
  int checks = 0;
  int lv_cnt = 0;
  int fe_cnt = 0;
  logic signed [RESULT_W-1:0] vals [N];

  xcorr_peak_lag #(.RESULT_W(RESULT_W), .MAX_LAG(MAX_LAG), .LAG_W(LAG_W), .MIN_PEAK(MIN_PEAK)) dut (
    .clk(clk), .rst(rst), .start(start), .result_valid(result_valid), .result(result),
    .lag_diff(lag_diff), .peak_value(peak_value), .lag_valid(lag_valid),
    .no_peak(no_peak), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lag_valid) lv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) vals[i] = v;
  endtask

  task automatic send_frame(input int first, input int cnt, input int smode, input int gap);
    int ng;
    if (smode == S_SEP) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = first; i < first + cnt; i++) begin
      ng = 0;
      if (gap == 1 && i > first) ng = 1;
      if (gap == 2) ng = $urandom_range(0, 2);
      if (smode == S_WITH && i == first) ng = 0;
      repeat (ng) tick();
      result_valid = 1'b1;
      result       = vals[i];
      start        = (smode == S_WITH && i == first);
      tick();
      result_valid = 1'b0;
      start        = 1'b0;
    end
  endtask

  // Reference: maximum over the frame, first occurrence wins, lag = index - MAX_LAG.
  task automatic check_frame(input string tag);
    int best;
    longint mx;
    best = 0;
    mx = vals[0];
    for (int i = 1; i < N; i++)
      if (longint'(vals[i]) > mx) begin
        mx = vals[i];
        best = i;
      end
    chk({tag, ".lag_valid"}, lag_valid, 1);
    chk({tag, ".lag_diff"}, lag_diff, best - MAX_LAG);
    chk({tag, ".peak_value"}, peak_value, mx);
    chk({tag, ".no_peak"}, no_peak, (mx <= MIN_PEAK) ? 1 : 0);
    tick();
    chk({tag, ".lag_valid_drop"}, lag_valid, 0);
    chk({tag, ".busy_idle"}, busy, 0);
  endtask

  initial begin
    int lv0, fe0, k;
    rst = 1'b1; start = 1'b0; result_valid = 1'b0; result = '0;
    repeat (2) tick();
    chk("rst.lag_diff", lag_diff, 0);
    chk("rst.peak_value", peak_value, 0);
    chk("rst.lag_valid", lag_valid, 0);
    chk("rst.no_peak", no_peak, 0);
    chk("rst.busy", busy, 0);
    chk("rst.frame_err", frame_err, 0);
    rst = 1'b0;
    tick();

    fill(-5); vals[31] = 1000;
    send_frame(0, N, S_SEP, 0);
    check_frame("centre");

    fill(-5); vals[0] = 700;
    send_frame(0, N, S_SEP, 0);
    check_frame("edge_lo");
    fill(-5); vals[62] = 700;
    send_frame(0, 31, S_SEP, 0);
    chk("hold.lag_diff", lag_diff, -31);
    chk("hold.busy", busy, 1);
    send_frame(31, 32, S_NONE, 0);
    check_frame("edge_hi");

    fill(0); vals[10] = 50; vals[40] = 50;
    lv0 = lv_cnt;
    send_frame(0, N - 1, S_SEP, 1);
    repeat (3) tick();
    chk("gap.no_early_valid", lv_cnt - lv0, 0);
    chk("gap.busy", busy, 1);
    send_frame(N - 1, 1, S_NONE, 0);
    check_frame("tie_gap");

    fill(-200);
    send_frame(0, N, S_SEP, 0);
    check_frame("weak");

    fill(3); vals[35] = 999;
    lv0 = lv_cnt; fe0 = fe_cnt;
    send_frame(0, 20, S_SEP, 0);
    send_frame(0, N, S_SEP, 0);
    check_frame("abort");
    chk("abort.frame_err_pulses", fe_cnt - fe0, 1);
    chk("abort.lag_valid_pulses", lv_cnt - lv0, 1);

    for (int i = 0; i < N; i++) vals[i] = $urandom_range(0, 99);
    lv0 = lv_cnt; fe0 = fe_cnt;
    send_frame(0, 30, S_SEP, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.lag_diff", lag_diff, 0);
    chk("midrst.peak_value", peak_value, 0);
    chk("midrst.no_peak", no_peak, 0);
    chk("midrst.busy", busy, 0);
    send_frame(0, N, S_NONE, 0);
    repeat (2) tick();
    chk("midrst.no_lag_valid", lv_cnt - lv0, 0);
    chk("midrst.no_frame_err", fe_cnt - fe0, 0);
    chk("midrst.busy_after", busy, 0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++)
        vals[i] = (r % 2 == 0) ? (int'($urandom_range(0, 15)) - 8) : $signed($urandom());
      lv0 = lv_cnt; fe0 = fe_cnt;
      if (r % 3 == 2) begin
        k = $urandom_range(1, 40);
        send_frame(0, k, S_SEP, 2);
        send_frame(0, N, S_WITH, 2);
      end else begin
        send_frame(0, N, S_SEP, 2);
      end
      check_frame($sformatf("rand%0d", r));
      chk($sformatf("rand%0d.frame_err", r), fe_cnt - fe0, (r % 3 == 2) ? 1 : 0);
      chk($sformatf("rand%0d.lag_valid_cnt", r), lv_cnt - lv0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
